// File: rtl/lsu_apb_bridge.sv
// Bridge from the core's req/gnt/rvalid data port to an APB3 master port.
// One access in flight; illegal requests are answered locally with an error.
module lsu_apb_bridge #(
  parameter int          APB_ADDR_WIDTH    = 32,
  parameter int          APB_DATA_WIDTH    = 32,
  parameter logic [31:0] PERIPH_START_ADDR = 32'h1A10_0000,
  parameter logic [31:0] PERIPH_END_ADDR   = 32'h1A11_7FFF,
  parameter int          TIMEOUT_CYCLES    = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [31:0]               data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic [2:0]                fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_legal;
  logic        wait_expired;

  // Handshake: a request is taken when data_req_i && data_gnt_o in IDLE; the
  // response is a single-cycle data_rvalid_o strobe, no back-pressure.
  assign req_legal = (data_addr_i >= PERIPH_START_ADDR) &&
                     (data_addr_i <= PERIPH_END_ADDR) &&
                     (data_addr_i[1:0] == 2'b00) &&
                     (!data_we_i || (data_be_i == 4'hF));

  assign wait_expired = (cnt_q == CNT_LIMIT);
  assign fsm_state    = state_q;

  always_comb begin
    state_d    = state_q;
    data_gnt_o = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i) state_d = req_legal ? S_SETUP : S_ERR;
      end
      S_SETUP: begin
        psel    = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || wait_expired) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs come straight from state so a reset kills them at once.
  assign data_rvalid_o = (state_q == S_RESP) || (state_q == S_ERR);
  assign data_rdata_o  = (state_q == S_RESP) ? rdata_q : 32'h0;
  assign data_err_o    = (state_q == S_RESP) ? err_q : (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && data_req_i && req_legal) begin
        paddr  <= APB_ADDR_WIDTH'(data_addr_i);
        pwrite <= data_we_i;
        cnt_q  <= 16'h0;
        if (data_we_i) pwdata <= APB_DATA_WIDTH'(data_wdata_i);
      end
      if (state_q == S_ACCESS) begin
        // pready wins over the timeout when both happen in the same cycle
        if (pready) begin
          rdata_q <= pwrite ? 32'h0 : 32'(prdata);
          err_q   <= pslverr;
        end else if (wait_expired) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 16'h1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Bench for lsu_apb_bridge: randomized and directed accesses, an APB slave
// model, and a scoreboard that checks every response and every APB cycle.
module tb_lsu_apb_bridge;

  localparam int          T      = 8;
  localparam logic [31:0] PSTART = 32'h1A10_0000;
  localparam logic [31:0] PEND   = 32'h1A11_7FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [2:0]  fsm_state;

  lsu_apb_bridge #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
    .PERIPH_START_ADDR(PSTART), .PERIPH_END_ADDR(PEND),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard state
  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_psel_q[$];
  logic        cur_legal = 1'b0;
  logic [31:0] cur_addr  = '0;
  logic        cur_we    = 1'b0;
  logic [31:0] cur_wdata = '0;

  // slave configuration for the access in flight
  int          cfg_waits  = 0;
  logic [31:0] cfg_rdata  = '0;
  logic        cfg_slverr = 1'b0;
  int          acc_cnt    = 0;

  function automatic logic is_legal(input logic [31:0] a, input logic we, input logic [3:0] be);
    return (a >= PSTART) && (a <= PEND) && (a[1:0] == 2'b00) && (!we || be == 4'hF);
  endfunction

  // APB slave: answers after cfg_waits wait states, drives junk otherwise
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acc_cnt == cfg_waits) begin
        pready  = 1'b1;
        prdata  = cfg_rdata;
        pslverr = cfg_slverr;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  end

  // monitor: APB phase checks and response scoreboard
  int          psel_run   = 0;
  int          psel_total = 0;
  logic [32:0] mon_e;
  int          mon_c;
  int          mon_p;
  always @(negedge clk) begin
    if (!rst) begin
      if (psel) begin
        check("psel_only_for_legal", 64'(cur_legal), 64'd1);
        check("penable_phase", 64'(penable), 64'(psel_run > 0));
        check("paddr", 64'(paddr), 64'(cur_addr));
        check("pwrite", 64'(pwrite), 64'(cur_we));
        if (cur_we) check("pwdata", 64'(pwdata), 64'(cur_wdata));
        psel_run++;
        psel_total++;
      end else begin
        check("penable_without_psel", 64'(penable), 64'd0);
        psel_run = 0;
      end
      if (data_rvalid_o) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 64'(data_rvalid_o), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          mon_p = exp_psel_q.pop_front();
          check("rdata", 64'(data_rdata_o), 64'(mon_e[31:0]));
          check("err", 64'(data_err_o), 64'(mon_e[32]));
          check("rvalid_cycle", 64'(cyc), 64'(mon_c));
          check("psel_cycles", 64'(psel_total), 64'(mon_p));
        end
        psel_total = 0;
      end
    end
  end

  // driver: issue one access, push its expected response, wait for it
  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input int waits, input logic [31:0] rd,
                       input logic serr);
    logic legal;
    int   lat;
    int   npsel;
    int   n;
    logic [32:0] e;
    legal = is_legal(a, we, be);
    @(negedge clk);
    cfg_waits = waits; cfg_rdata = rd; cfg_slverr = serr;
    cur_legal = legal; cur_addr = a; cur_we = we; cur_wdata = wd;
    data_req_i = 1'b1; data_addr_i = a; data_we_i = we; data_be_i = be; data_wdata_i = wd;
    #1;
    check("gnt", 64'(data_gnt_o), 64'd1);
    if (!legal) begin
      lat = 1; npsel = 0; e = {1'b1, 32'h0};
    end else if (waits < T) begin
      lat = 3 + waits; npsel = waits + 2; e = {serr, we ? 32'h0 : rd};
    end else begin
      lat = T + 2; npsel = T + 1; e = {1'b1, 32'h0};
    end
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + lat);
    exp_psel_q.push_back(npsel);
    @(posedge clk); #1;
    data_req_i = 1'b0; data_addr_i = $urandom; data_we_i = 1'($urandom_range(0, 1));
    data_wdata_i = $urandom;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("response_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete(); exp_cyc_q.delete(); exp_psel_q.delete();
    end
  endtask

  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  int          sel;

  initial begin
    rst = 1'b1;
    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_pwrite", 64'(pwrite), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rvalid", 64'(data_rvalid_o), 64'd0);
    check("rst_err", 64'(data_err_o), 64'd0);
    check("rst_rdata", 64'(data_rdata_o), 64'd0);
    check("rst_gnt", 64'(data_gnt_o), 64'd0);
    rst = 1'b0;

    // directed cases
    issue(32'h1A10_1000, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    issue(32'h1A10_3004, 1'b1, 4'hF, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0);
    issue(32'h1A12_0000, 1'b0, 4'hF, 32'h0, 0, 32'h1111_1111, 1'b0);
    issue(32'h1A10_0002, 1'b0, 4'hF, 32'h0, 0, 32'h2222_2222, 1'b0);
    issue(32'h1A10_2000, 1'b1, 4'h3, 32'hA5A5_A5A5, 0, 32'h3333_3333, 1'b0);
    issue(32'h1A10_0010, 1'b0, 4'h0, 32'h0, 1, 32'h4444_4444, 1'b1);
    issue(32'h1A10_0014, 1'b1, 4'hF, 32'h5555_5555, 0, 32'h0, 1'b0);
    issue(32'h1A10_0100, 1'b0, 4'hF, 32'h0, 50, 32'h6666_6666, 1'b0);
    issue(32'h1A10_0104, 1'b0, 4'hF, 32'h0, T - 1, 32'h7777_7777, 1'b0);
    issue(PSTART, 1'b0, 4'hF, 32'h0, 2, 32'h8888_8888, 1'b0);
    issue(PEND - 32'd3, 1'b1, 4'hF, 32'h9999_9999, 1, 32'h0, 1'b1);
    issue(PEND + 32'd1, 1'b0, 4'hF, 32'h0, 0, 32'hAAAA_AAAA, 1'b0);
    issue(PSTART - 32'd4, 1'b0, 4'hF, 32'h0, 0, 32'hBBBB_BBBB, 1'b0);

    // reset during the second ACCESS cycle
    @(negedge clk);
    cfg_waits = 100; cur_legal = 1'b1; cur_addr = 32'h1A10_0040; cur_we = 1'b0;
    data_req_i = 1'b1; data_addr_i = 32'h1A10_0040; data_we_i = 1'b0; data_be_i = 4'hF;
    @(posedge clk); #1 data_req_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_penable", 64'(penable), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_psel", 64'(psel), 64'd0);
    check("rst_abort_penable", 64'(penable), 64'd0);
    check("rst_abort_rvalid", 64'(data_rvalid_o), 64'd0);
    rst = 1'b0;
    psel_run = 0; psel_total = 0;
    @(posedge clk); #1;
    check("post_rst_rvalid", 64'(data_rvalid_o), 64'd0);
    issue(32'h1A10_0040, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_CAFE, 1'b0);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      sel  = $urandom_range(0, 5);
      r_we = 1'($urandom_range(0, 1));
      r_be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (sel)
        0:       r_addr = PSTART + 32'($urandom_range(0, 1000)) * 32'd4;
        1:       r_addr = PEND - 32'd3;
        2:       r_addr = PEND + 32'($urandom_range(1, 64));
        3:       r_addr = PSTART - 32'($urandom_range(1, 64));
        4:       r_addr = PSTART + 32'($urandom_range(0, 32'h17FFF));
        default: r_addr = $urandom;
      endcase
      issue(r_addr, r_we, r_be, $urandom, $urandom_range(0, 10), $urandom,
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
